// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by the fetch stage and the decoder.
package riscv_pkg;

  // Canonical NOP: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Major opcodes (instr[6:0]) consumed by the decoder
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    READY = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {pc, instr} holding slot used while ID is stalled.
// clear wins over push, push wins over pop (a same-cycle pop+push refills).
module fetch_skid_buf
  import riscv_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [PC_W-1:0] push_pc,
  input  logic [31:0]     push_instr,
  output logic            full,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     instr
);

  // occupancy flag
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  // stored entry, only written on push
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (push && !clear) begin
      pc    <= push_pc;
      instr <= push_instr;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, single-outstanding instruction fetch and the
// IF/ID pipeline register feeding the decoder.
// Build option: define FETCH_STATS_EN to add the stat_fetched/stat_dropped
// saturating counters and their output ports.
//
// state | meaning
// READY | nothing outstanding
// WAIT  | one request outstanding, its PC held in req_pc_q
// DROP  | one request outstanding whose response will be discarded
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [PC_W-1:0] if_id_pc,
  output logic [31:0]     if_id_instr
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_dropped
`endif
);

  localparam logic [PC_W-1:0] WORD_MASK = ~PC_W'(3);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, req_pc_q;

  logic            rsp_keep;
  logic            to_skid;
  logic            skid_pop;
  logic            skid_full;
  logic            skid_full_next;
  logic            load_rsp;
  logic            issue;
  logic [PC_W-1:0] skid_pc;
  logic [31:0]     skid_instr;

  // A response is only kept when it belongs to WAIT and no redirect is pending.
  // While ID is stalled on a valid entry, or the skid must drain first, it parks.
  assign rsp_keep       = (state_q == WAIT) && imem_rvalid && !flush;
  assign to_skid        = rsp_keep && ((stall && if_id_valid) || (!stall && skid_full));
  assign skid_pop       = !flush && !stall && skid_full;
  assign skid_full_next = !flush && ((skid_full && stall) || to_skid);
  assign load_rsp       = rsp_keep && !to_skid;
  assign issue          = !reset && !flush && !skid_full_next &&
                          ((state_q == READY) || ((state_q != READY) && imem_rvalid));
  assign imem_addr      = pc_q;

  fetch_skid_buf #(.PC_W(PC_W)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (to_skid),
    .pop        (skid_pop),
    .clear      (flush),
    .push_pc    (req_pc_q),
    .push_instr (imem_rdata),
    .full       (skid_full),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= READY;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and request. A response landing while already in DROP ends the
  // outstanding fetch even under a new flush, otherwise nothing would ever
  // leave DROP.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    if (flush) begin
      case (state_q)
        WAIT:    state_d = imem_rvalid ? READY : DROP;
        DROP:    state_d = imem_rvalid ? READY : DROP;
        default: state_d = READY;
      endcase
    end else if (issue) begin
      imem_req = 1'b1;
      state_d  = WAIT;
    end else if ((state_q != READY) && imem_rvalid) begin
      state_d = READY;
    end
  end

  // fetch PC and the PC of the request in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC & WORD_MASK;
      req_pc_q <= '0;
    end else if (flush) begin
      pc_q <= redirect_pc & WORD_MASK;
    end else if (issue) begin
      req_pc_q <= pc_q;
      pc_q     <= pc_q + PC_W'(4);
    end
  end

  // IF/ID register: flush, then skid drain, then fresh response, else bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
    end else if (flush) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (skid_pop) begin
      if_id_valid <= 1'b1;
      if_id_pc    <= skid_pc;
      if_id_instr <= skid_instr;
    end else if (load_rsp) begin
      if_id_valid <= 1'b1;
      if_id_pc    <= req_pc_q;
      if_id_instr <= imem_rdata;
    end else if (!stall) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end
  end

`ifdef FETCH_STATS_EN
  logic fetched_evt;
  logic dropped_evt;

  assign fetched_evt = skid_pop || load_rsp;
  assign dropped_evt = imem_rvalid &&
                       (((state_q == WAIT) && flush) || (state_q == DROP));

  // saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched <= '0;
      stat_dropped <= '0;
    end else begin
      if (fetched_evt && (stat_fetched != 32'hFFFF_FFFF)) begin
        stat_fetched <= stat_fetched + 32'd1;
      end
      if (dropped_evt && (stat_dropped != 32'hFFFF_FFFF)) begin
        stat_dropped <= stat_dropped + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: bench for fetch_stage with a behavioural instruction memory
// and an in-order scoreboard of fetched {pc, instr} pairs.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_dropped;
`endif

  int checks = 0;
  int errors = 0;
  int loads  = 0;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_dropped(stat_dropped)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[24:0], 7'h13};
  endfunction

  // memory model: one outstanding request, response mem_lat cycles after issue
  logic        rst_s = 1'b1;
  logic        req_s = 1'b0;
  logic [31:0] addr_s = '0;
  int          mem_lat = 1;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;

  always @(posedge clk) begin
    logic busy_before;
    #1;
    imem_rvalid = 1'b0;
    busy_before = mem_busy;
    if (rst_s) begin
      mem_busy = 1'b0;
    end else begin
      if (mem_busy) begin
        if (mem_cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_addr);
          mem_busy    = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      if (req_s) begin
        checks++;
        if (busy_before) begin
          errors++;
          $display("FAIL mem_overlap: request addr=%h issued while addr=%h outstanding", addr_s, mem_addr);
        end
        mem_busy = 1'b1;
        mem_addr = addr_s;
        mem_cnt  = mem_lat;
      end
    end
  end

  // scoreboard monitor: expected entries pushed on request, popped on IF/ID load
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];
  exp_t exp_e;
  logic last_valid = 1'b0;
  logic last_stall = 1'b0;

  always @(negedge clk) begin
    rst_s  = reset;
    req_s  = imem_req;
    addr_s = imem_addr;
    if (reset) begin
      exp_q.delete();
      last_valid = 1'b0;
      last_stall = 1'b0;
    end else begin
      if (if_id_valid && !(last_stall && last_valid)) begin
        checks++;
        loads++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_load: got pc=%h instr=%h, required no load (nothing pending)", if_id_pc, if_id_instr);
        end else begin
          exp_e = exp_q.pop_front();
          if (if_id_pc !== exp_e.pc || if_id_instr !== exp_e.instr) begin
            errors++;
            $display("FAIL sb_load: got pc=%h instr=%h, required pc=%h instr=%h", if_id_pc, if_id_instr, exp_e.pc, exp_e.instr);
          end
        end
      end
      if (!if_id_valid) begin
        checks++;
        if (if_id_instr !== NOP_INSTR) begin
          errors++;
          $display("FAIL sb_nop: got instr=%h, required %h", if_id_instr, NOP_INSTR);
        end
      end
      if (imem_req) begin
        checks++;
        if (imem_addr[1:0] !== 2'b00) begin
          errors++;
          $display("FAIL sb_align: got addr=%h, required word aligned", imem_addr);
        end
        exp_q.push_back({imem_addr, mem_word(imem_addr)});
      end
      if (flush) exp_q.delete();
      last_valid = if_id_valid;
      last_stall = stall;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves the caller at the start of the first cycle after reset (c0)
  task automatic do_reset(input int lat);
    tick();
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    mem_lat = lat;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", imem_req); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", if_id_valid); end
    checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h required 0", if_id_pc); end
    checks++; if (if_id_instr !== NOP_INSTR) begin errors++; $display("FAIL reset_instr: got %h required %h", if_id_instr, NOP_INSTR); end
`ifdef FETCH_STATS_EN
    checks++; if (stat_fetched !== 32'h0) begin errors++; $display("FAIL reset_stat_fetched: got %0d required 0", stat_fetched); end
    checks++; if (stat_dropped !== 32'h0) begin errors++; $display("FAIL reset_stat_dropped: got %0d required 0", stat_dropped); end
`endif
  endtask

  task automatic test_fetch();
    logic        e_req  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] e_addr [6] = '{32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'h0};
    logic        e_val  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] e_pc   [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4};
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== e_req[i]) begin errors++; $display("FAIL fetch_req[%0d]: got %b required %b", i, imem_req, e_req[i]); end
      if (e_req[i]) begin
        checks++;
        if (imem_addr !== e_addr[i]) begin errors++; $display("FAIL fetch_addr[%0d]: got %h required %h", i, imem_addr, e_addr[i]); end
      end
      checks++;
      if (if_id_valid !== e_val[i]) begin errors++; $display("FAIL fetch_valid[%0d]: got %b required %b", i, if_id_valid, e_val[i]); end
      if (e_val[i]) begin
        checks++;
        if (if_id_pc !== e_pc[i] || if_id_instr !== mem_word(e_pc[i])) begin
          errors++; $display("FAIL fetch_ifid[%0d]: got pc=%h instr=%h required pc=%h instr=%h", i, if_id_pc, if_id_instr, e_pc[i], mem_word(e_pc[i]));
        end
      end
      tick();
    end
  endtask

  task automatic test_skid();
    do_reset(1);
    tick(); tick(); tick();
    stall = 1'b1;
    @(negedge clk);
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== 32'h0050_0093) begin
      errors++; $display("FAIL skid_first: got v=%b pc=%h instr=%h required v=1 pc=0 instr=00500093", if_id_valid, if_id_pc, if_id_instr); end
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL skid_noreq[%0d]: got %b required 0", i, imem_req); end
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0) begin
        errors++; $display("FAIL skid_hold[%0d]: got v=%b pc=%h required v=1 pc=0", i, if_id_valid, if_id_pc); end
    end
    tick();
    stall = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL skid_resume: got req=%b addr=%h required req=1 addr=8", imem_req, imem_addr); end
    tick();
    @(negedge clk);
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4 || if_id_instr !== mem_word(32'h4)) begin
      errors++; $display("FAIL skid_drain: got v=%b pc=%h instr=%h required v=1 pc=4 instr=%h", if_id_valid, if_id_pc, if_id_instr, mem_word(32'h4)); end
  endtask

  task automatic test_flush();
    int n;
    do_reset(3);
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL flush_first: got req=%b addr=%h required req=1 addr=0", imem_req, imem_addr); end
    tick();
    flush = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL flush_noreq: got %b required 0", imem_req); end
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0) begin
        errors++; $display("FAIL flush_drop[%0d]: got req=%b v=%b required req=0 v=0", i, imem_req, if_id_valid); end
      tick();
    end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL flush_redirect: got req=%b addr=%h v=%b required req=1 addr=40 v=0", imem_req, imem_addr, if_id_valid); end
    tick();
    @(negedge clk);
`ifdef FETCH_STATS_EN
    checks++; if (stat_dropped !== 32'd1 || stat_fetched !== 32'd0) begin
      errors++; $display("FAIL flush_stats: got dropped=%0d fetched=%0d required dropped=1 fetched=0", stat_dropped, stat_fetched); end
`endif
    n = 0;
    while (n < 10) begin
      tick();
      @(negedge clk);
      if (if_id_valid) break;
      n++;
    end
    checks++; if (n != 3 || if_id_pc !== 32'h40 || if_id_instr !== mem_word(32'h40)) begin
      errors++; $display("FAIL flush_target: got wait=%0d pc=%h instr=%h required wait=3 pc=40 instr=%h", n, if_id_pc, if_id_instr, mem_word(32'h40)); end
  endtask

  task automatic test_flush_stall();
    int n;
    do_reset(1);
    tick(); tick(); tick();
    stall = 1'b1;
    tick(); tick();
    flush = 1'b1;
    redirect_pc = 32'h40;
    tick();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP_INSTR) begin
      errors++; $display("FAIL fs_ifid: got v=%b instr=%h required v=0 instr=%h", if_id_valid, if_id_instr, NOP_INSTR); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL fs_pc: got req=%b addr=%h required req=1 addr=40", imem_req, imem_addr); end
    tick();
    stall = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (if_id_valid) break;
      tick();
      n++;
    end
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40) begin
      errors++; $display("FAIL fs_skid_empty: got v=%b pc=%h required v=1 pc=40", if_id_valid, if_id_pc); end
`ifdef FETCH_STATS_EN
    checks++; if (stat_fetched !== 32'd2) begin
      errors++; $display("FAIL fs_stat_fetched: got %0d required 2", stat_fetched); end
`endif
  endtask

  task automatic test_align();
    do_reset(1);
    flush = 1'b1;
    redirect_pc = 32'h43;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL align_noreq: got %b required 0", imem_req); end
    tick();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL align_addr: got req=%b addr=%h required req=1 addr=40", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset(1);
    flush = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_top: got req=%b addr=%h required req=1 addr=fffffffc", imem_req, imem_addr); end
    tick(); tick();
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_next: got req=%b addr=%h required req=1 addr=0", imem_req, imem_addr); end
    tick();
    @(negedge clk);
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_ifid: got v=%b pc=%h required v=1 pc=fffffffc", if_id_valid, if_id_pc); end
  endtask

  task automatic test_back_to_back();
    int loads0;
    do_reset(1);
    loads0 = loads;
    for (int i = 0; i < 300; i++) begin
      tick();
      stall       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      mem_lat     = $urandom_range(1, 2);
    end
    tick();
    stall = 1'b0;
    flush = 1'b0;
    repeat (10) tick();
    checks++; if (loads - loads0 < 20) begin
      errors++; $display("FAIL b2b_progress: got %0d loads required at least 20", loads - loads0); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_skid();
    test_flush();
    test_flush_stall();
    test_align();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
